slowclk_phase_ctrl: RTL and testbench
=====================================

# slowclk_phase_ctrl

Sequences a fast-clock datapath from the first-edge pulses produced by the slow/fast clock edge aligner. Measures the slow-to-fast clock ratio in fast-clock cycles and locks once the period is stable. While locked, it drives a free-running phase index and a load strobe for the gearbox/serializer. It also flags slips when a slow edge arrives off-schedule or is missed.

## Interface
- CW, 4: width of period counter, phase and ratio; max measurable period 2^CW-1
- LOCKCOUNT, 4: consecutive equal periods required to lock (1..2^CW-1)
- clk  in  1  fast clock (same clock that samples the aligner output)
- reset  in  1  asynchronous, active-high reset
- en  in  1  enable; 0 forces IDLE
- firstedge  in  1  one-cycle pulse per slow-clock rising edge, from edge aligner
- phase  out  CW  fast-cycle index within slow period, 0..ratio-1 while locked, else 0
- load  out  1  high in cycles where locked and phase==0
- ratio  out  CW  locked period in fast cycles; 0 when not locked
- locked  out  1  lock status
- slip_err  out  1  one-cycle pulse on loss of alignment or measurement timeout

## Operation
- All outputs registered; reset values: phase=0, load=0, ratio=0, locked=0, slip_err=0; state=IDLE, cnt=0, cand=0, match=0.
- Internal state: cnt (CW) counts fast cycles since last edge; cand (CW) is the candidate period; match counts equal periods.
- IDLE: cnt/cand/match held at 0. On en & firstedge: go to MEASURE, cnt<=1.
- MEASURE: cnt increments each cycle. On firstedge, period=cnt and cnt<=1.
  - If period<2, treat as invalid: cand<=0, match<=0.
  - Else if period==cand: match<=match+1.
  - Else: cand<=period, match<=1.
  - When the updated match reaches LOCKCOUNT: go to LOCKED, ratio<=cand, locked<=1, phase<=0.
- MEASURE timeout: if cnt==2^CW-1 with no edge, go to IDLE with slip_err pulse.
- LOCKED: phase increments each cycle and wraps from ratio-1 to 0.
  - Expected case: firstedge coincides with phase==ratio-1. Stay LOCKED.
  - Early edge (firstedge with phase!=ratio-1): slip_err pulse, locked<=0, ratio<=0, phase<=0. Go to MEASURE with cnt<=1, cand<=0, match<=0.
  - Missing edge (phase==ratio-1 without firstedge): slip_err pulse, locked<=0, ratio<=0, phase<=0. Go to IDLE.
- en=0 in any state: next cycle is IDLE with all outputs 0, no slip_err. en=0 overrides a simultaneous firstedge.
- reset overrides everything, immediately, including mid-lock.

## Timing
- Edge to lock: locked=1, phase=0 and load=1 appear the cycle after the edge completing the LOCKCOUNT-th equal period.
- Steady state: load is a 1-cycle pulse every ratio cycles, always one cycle after the sampled firstedge.
- slip_err is high for exactly one cycle, in the cycle after the detecting edge (or missing-edge) cycle. locked falls in that same cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package: state encoding (IDLE, MEASURE, LOCKED), CW/LOCKCOUNT defaults.
- One natural sub-module: slowclk_period_cnt, the saturating edge-to-edge cycle counter with period output and timeout flag.
- The FSM, match logic and phase counter live in the top module.

## Test plan
1. Lock at ratio 4: CW=4, LOCKCOUNT=4, en=1, firstedge at cycles 0,4,8,12,16.
   - Required: locked=1, ratio=4, phase=0, load=1 at cycle 17.
   - Then load at 21, 25, ...; phase sequence 0,1,2,3,0.
2. Unstable period: edges give periods 4,4,5,5,5,5.
   - Required: no lock after the 4,4 pair; cand becomes 5 at the first 5.
   - Required: lock with ratio=5 one cycle after the fourth 5-period edge.
3. Missing edge: locked at ratio 4, suppress one firstedge.
   - Required: slip_err=1 for one cycle, locked=0, ratio=0, state IDLE.
   - Required: the next edge restarts measurement.
4. Early edge: locked at ratio 6, firstedge arrives at phase 2.
   - Required: slip_err pulse, locked=0, state MEASURE with cnt=1.
   - Required: relock after 4 further 6-cycle periods.
5. Timeout: one edge, then none for 15 cycles.
   - Required: slip_err pulse when cnt hits 15; state IDLE; locked stays 0.
6. Control: assert reset mid-lock.
   - Required: all outputs 0 immediately.
   - en=0 with a coincident firstedge: outputs 0 next cycle, no slip_err.

Source files
------------

// File: rtl/slowclk_phase_ctrl_pkg.sv
// Shared definitions for the slow-clock phase controller: FSM state encoding
// and default widths/lock threshold.
package slowclk_phase_ctrl_pkg;

    localparam int CW_DEFAULT        = 4;
    localparam int LOCKCOUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/slowclk_period_cnt.sv
// Saturating edge-to-edge fast-cycle counter. The count at an edge is the
// measured period; timeout_o flags that the counter has reached its maximum.
module slowclk_period_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          restart_i,
    input  logic          run_i,
    output logic [CW-1:0] period_o,
    output logic          timeout_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        // NOTE: next-state defaults to the held value first, so no path through this block can infer a latch.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (restart_i) begin
            cnt_d = CW'(1);
        end else if (run_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign period_o  = cnt_q;
    assign timeout_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/slowclk_phase_ctrl.sv
// Measures the slow/fast clock ratio from aligner first-edge pulses, locks on a
// stable period and then drives a free-running phase index and load strobe.
module slowclk_phase_ctrl
    import slowclk_phase_ctrl_pkg::*;
#(
    parameter int CW        = CW_DEFAULT,
    parameter int LOCKCOUNT = LOCKCOUNT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          firstedge,
    output logic [CW-1:0] phase,
    output logic          load,
    output logic [CW-1:0] ratio,
    output logic          locked,
    output logic          slip_err
);

    state_e        state_q;
    logic [CW-1:0] cand_q;
    logic [CW-1:0] match_q;
    logic [CW-1:0] phase_q;
    logic [CW-1:0] ratio_q;
    logic          locked_q;
    logic          load_q;
    logic          slip_q;

    logic [CW-1:0] period;
    logic          timeout;
    logic          cnt_clear;
    logic          cnt_restart;
    logic          cnt_run;

    logic          period_ok;
    logic [CW-1:0] match_nx;
    logic          lock_hit;
    logic          at_last;

    slowclk_period_cnt #(.CW(CW)) u_period_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (cnt_clear),
        .restart_i (cnt_restart),
        .run_i     (cnt_run),
        .period_o  (period),
        .timeout_o (timeout)
    );

    // Periods of 0 or 1 cycle are back-to-back edges and never count toward lock.
    always_comb begin
        period_ok = (period >= CW'(2));
        match_nx  = (period == cand_q) ? (match_q + CW'(1)) : CW'(1);
        lock_hit  = period_ok && (match_nx == CW'(LOCKCOUNT));
        at_last   = (phase_q == (ratio_q - CW'(1)));

        cnt_clear   = 1'b1;
        cnt_restart = 1'b0;
        cnt_run     = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (firstedge) begin
                        cnt_clear   = 1'b0;
                        cnt_restart = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (firstedge) begin
                        cnt_clear   = 1'b0;
                        cnt_restart = 1'b1;
                    end else if (!timeout) begin
                        cnt_clear = 1'b0;
                        cnt_run   = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (firstedge && !at_last) begin
                        cnt_clear   = 1'b0;
                        cnt_restart = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cand_q   <= '0;
            match_q  <= '0;
            phase_q  <= '0;
            ratio_q  <= '0;
            locked_q <= 1'b0;
            load_q   <= 1'b0;
            slip_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            slip_q <= 1'b0;
            if (!en) begin
                state_q  <= ST_IDLE;
                cand_q   <= '0;
                match_q  <= '0;
                phase_q  <= '0;
                ratio_q  <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cand_q  <= '0;
                        match_q <= '0;
                        if (firstedge) begin
                            state_q <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (firstedge) begin
                            if (!period_ok) begin
                                cand_q  <= '0;
                                match_q <= '0;
                            end else begin
                                cand_q  <= period;
                                match_q <= match_nx;
                            end
                            if (lock_hit) begin
                                state_q  <= ST_LOCKED;
                                ratio_q  <= period;
                                locked_q <= 1'b1;
                                phase_q  <= '0;
                                load_q   <= 1'b1;
                            end
                        end else if (timeout) begin
                            state_q <= ST_IDLE;
                            slip_q  <= 1'b1;
                            cand_q  <= '0;
                            match_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (firstedge && at_last) begin
                            phase_q <= '0;
                            load_q  <= 1'b1;
                        end else if (firstedge || at_last) begin
                            // Early edge re-measures at once; a missing edge drops to IDLE.
                            state_q  <= firstedge ? ST_MEASURE : ST_IDLE;
                            slip_q   <= 1'b1;
                            locked_q <= 1'b0;
                            ratio_q  <= '0;
                            phase_q  <= '0;
                            cand_q   <= '0;
                            match_q  <= '0;
                        end else begin
                            phase_q <= phase_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign phase    = phase_q;
    assign load     = load_q;
    assign ratio    = ratio_q;
    assign locked   = locked_q;
    assign slip_err = slip_q;

endmodule

// File: tb/tb_slowclk_phase_ctrl.sv
// Scoreboard bench for slowclk_phase_ctrl: a timestamp-based reference model
// predicts every cycle's outputs; a monitor compares them on the falling edge.
module tb_slowclk_phase_ctrl;

    localparam int CW   = 4;
    localparam int LC   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          firstedge;
    logic [CW-1:0] phase;
    logic          load;
    logic [CW-1:0] ratio;
    logic          locked;
    logic          slip_err;

    slowclk_phase_ctrl #(.CW(CW), .LOCKCOUNT(LC)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .firstedge (firstedge),
        .phase     (phase),
        .load      (load),
        .ratio     (ratio),
        .locked    (locked),
        .slip_err  (slip_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int phase;
        int ratio;
        int load;
        int locked;
        int slip;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: mode 0=idle, 1=measuring, 2=locked; works on edge timestamps.
    int m_mode  = 0;
    int t_ref   = 0;
    int t_l     = 0;
    int m_ratio = 0;
    int per_q[$];

    function automatic bit last_equal();
        for (int i = 1; i <= LC; i++) begin
            if (per_q[per_q.size() - i] != per_q[per_q.size() - 1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t model_step(input int t, input bit e, input bit f);
        exp_t x;
        int   p;
        bit   due;
        x.cyc = t + 1; x.phase = 0; x.ratio = 0; x.load = 0; x.locked = 0; x.slip = 0;
        if (!e) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (f) begin
                m_mode = 1; t_ref = t; per_q.delete();
            end
        end else if (m_mode == 1) begin
            if (f) begin
                p = t - t_ref;
                t_ref = t;
                if (p < 2) per_q.delete();
                else per_q.push_back(p);
                if (per_q.size() >= LC && last_equal()) begin
                    m_mode = 2; m_ratio = p; t_l = t;
                    x.locked = 1; x.ratio = p; x.load = 1;
                end
            end else if (t - t_ref == MAXC) begin
                m_mode = 0; x.slip = 1;
            end
        end else begin
            due = ((t - t_l) % m_ratio) == 0;
            if (f && due) begin
                x.locked = 1; x.ratio = m_ratio; x.load = 1;
            end else if (f) begin
                m_mode = 1; t_ref = t; per_q.delete(); x.slip = 1;
            end else if (due) begin
                m_mode = 0; x.slip = 1;
            end else begin
                x.locked = 1; x.ratio = m_ratio; x.phase = (t - t_l) % m_ratio;
            end
        end
        return x;
    endfunction

    task automatic drive(input bit e, input bit f);
        @(posedge clk);
        #1;
        en        = e;
        firstedge = f;
        sb_q.push_back(model_step(cyc, e, f));
    endtask

    task automatic pulse_after(input int k);
        repeat (k - 1) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
    endtask

    task automatic train(input int per, input int n);
        repeat (n) pulse_after(per);
    endtask

    task automatic gap(input int k);
        repeat (k) drive(1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},  phase,    0);
        check({tag, "_load"},   load,     0);
        check({tag, "_ratio"},  ratio,    0);
        check({tag, "_locked"}, locked,   0);
        check({tag, "_slip"},   slip_err, 0);
    endtask

    task automatic release_reset();
        m_mode = 0;
        per_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.push_back(model_step(cyc, en, firstedge));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset     = 1'b1;
        en        = 1'b0;
        firstedge = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb_q.delete();
        release_reset();
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (!reset && sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                x = sb_q.pop_front();
                check("phase",    phase,    x.phase);
                check("load",     load,     x.load);
                check("ratio",    ratio,    x.ratio);
                check("locked",   locked,   x.locked);
                check("slip_err", slip_err, x.slip);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int r;
        reset     = 1'b0;
        en        = 1'b0;
        firstedge = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        @(posedge clk);
        release_reset();

        // Lock at ratio 4, then steady state.
        drive(1'b1, 1'b1); train(4, 4); train(4, 3);
        // Unstable periods 4,4 then 5,5,5,5.
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1); train(4, 2); train(5, 4); train(5, 2);
        // Missing edge at ratio 4, then restart.
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1); train(4, 5); gap(6);
        drive(1'b1, 1'b1); train(4, 5);
        // Early edge at phase 2 at ratio 6, then relock.
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1); train(6, 4); pulse_after(3); train(6, 4); train(6, 2);
        // Measurement timeout.
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1); gap(20);
        // Reset mid-lock, then en=0 with a coincident edge while locked.
        drive(1'b1, 1'b1); train(4, 6);
        do_reset();
        drive(1'b1, 1'b1); train(4, 5); gap(3);
        drive(1'b0, 1'b1); gap(2);
        // Back-to-back edges are invalid periods.
        drive(1'b1, 1'b1); drive(1'b1, 1'b1); train(3, 5);

        repeat (30) begin
            r = $urandom_range(2, 9);
            train(r, $urandom_range(2, 7));
            case ($urandom_range(0, 5))
                0: pulse_after($urandom_range(1, r - 1));
                1: gap(r + $urandom_range(0, 3));
                2: drive(1'b0, 1'($urandom_range(0, 1)));
                3: gap(MAXC + 2);
                4: begin drive(1'b1, 1'b1); drive(1'b1, 1'b1); end
                default: ;
            endcase
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
